// File: rtl/ssm_pkg.sv
// Shared types and width helpers for the streaming product accumulator.
package ssm_pkg;

    localparam int unsigned DefN   = 16;
    localparam int unsigned DefLen = 16;

    // 2-bit frame state: Idle (no partial sum), Acc (partial sum), Hold (result presented)
    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StAcc  = 2'b01,
        StHold = 2'b10
    } state_e;

    // Accumulator width that cannot overflow for len full-scale n x n products
    function automatic int unsigned acc_width(input int unsigned n, input int unsigned len);
        return 2 * n + $clog2(len);
    endfunction

    // Counter width able to hold the value len
    function automatic int unsigned cnt_width(input int unsigned len);
        return $clog2(len + 1);
    endfunction

endpackage

// File: rtl/ssm_acc_if.sv
// Product-in / result-out handshake bundle for ssm_acc.
// slave: the accumulator side; master: the producer/consumer side.
interface ssm_acc_if
    import ssm_pkg::*;
#(
    parameter int unsigned N     = DefN,
    parameter int unsigned ACC_W = acc_width(DefN, DefLen)
) ();

    logic             prod_valid;
    logic             prod_ready;
    logic [2*N-1:0]   prod;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] acc_out;
    logic             out_ovf;

    modport slave (
        input  prod_valid, prod, out_ready,
        output prod_ready, out_valid, acc_out, out_ovf
    );

    modport master (
        output prod_valid, prod, out_ready,
        input  prod_ready, out_valid, acc_out, out_ovf
    );

endinterface

// File: rtl/ssm_sat_add.sv
// Combinational accumulator adder: ACC_W-bit partial sum plus 2N-bit product.
// Build option SSM_ACC_SAT_EN clamps the sum to all-ones on carry out;
// otherwise the sum wraps. The carry is reported in both builds.
module ssm_sat_add
    import ssm_pkg::*;
#(
    parameter int unsigned N     = DefN,
    parameter int unsigned ACC_W = acc_width(DefN, DefLen)
) (
    input  logic [ACC_W-1:0] i_acc,
    input  logic [2*N-1:0]   i_addend,
    output logic [ACC_W-1:0] o_sum,
    output logic             o_carry
);

    logic [ACC_W:0] w_raw;

    // One extra bit captures the carry out of the accumulator width
    always_comb begin
        w_raw   = {1'b0, i_acc} + (ACC_W + 1)'(i_addend);
        o_carry = w_raw[ACC_W];
`ifdef SSM_ACC_SAT_EN
        // Once clamped, any further addend carries again, so the clamp persists
        o_sum   = o_carry ? {ACC_W{1'b1}} : w_raw[ACC_W-1:0];
`else
        o_sum   = w_raw[ACC_W-1:0];
`endif
    end

endmodule

// File: rtl/ssm_acc.sv
// Streaming MAC back end: accumulates LEN products per frame and presents the
// sum with a sticky overflow flag on a valid/ready result channel.
// Build option SSM_ACC_SAT_EN selects saturating instead of wrapping sums.
module ssm_acc
    import ssm_pkg::*;
#(
    parameter int unsigned N     = DefN,
    parameter int unsigned LEN   = DefLen,
    parameter int unsigned ACC_W = acc_width(N, LEN)
) (
    input  logic         clk,
    input  logic         rst_n,
    ssm_acc_if.slave     bus,
    output logic         busy
);

    localparam int unsigned CntW = cnt_width(LEN);

    if (LEN < 1) begin : g_len_chk
        $error("ssm_acc: LEN must be at least 1");
    end
    if (ACC_W < 2 * N) begin : g_accw_chk
        $error("ssm_acc: ACC_W must be at least 2*N");
    end

    state_e           r_state;
    state_e           w_state_nxt;
    logic [ACC_W-1:0] r_acc;
    logic [CntW-1:0]  r_cnt;
    logic             r_ovf;
    logic [ACC_W-1:0] r_acc_out;
    logic             r_out_ovf;

    logic             w_xfer;
    logic             w_last;
    logic [ACC_W-1:0] w_sum;
    logic             w_carry;
    logic [ACC_W-1:0] w_acc_nxt;
    logic             w_ovf_nxt;

    ssm_sat_add #(
        .N     (N),
        .ACC_W (ACC_W)
    ) u_sat_add (
        .i_acc    (r_acc),
        .i_addend (bus.prod),
        .o_sum    (w_sum),
        .o_carry  (w_carry)
    );

    // Value the accumulator takes on a transfer; the first word of a frame restarts it
    always_comb begin
        w_xfer = bus.prod_valid & (r_state != StHold);
        if (r_state == StIdle) begin
            w_acc_nxt = ACC_W'(bus.prod);
            w_ovf_nxt = 1'b0;
            w_last    = (LEN == 1);
        end else begin
            w_acc_nxt = w_sum;
            w_ovf_nxt = r_ovf | w_carry;
            w_last    = (r_cnt == CntW'(LEN - 1));
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StIdle: if (w_xfer) w_state_nxt = w_last ? StHold : StAcc;
            StAcc:  if (w_xfer && w_last) w_state_nxt = StHold;
            StHold: if (bus.out_ready) w_state_nxt = StIdle;
            default: w_state_nxt = StIdle;
        endcase
    end

    // Handshake outputs decoded from state only; no path from out_ready to prod_ready
    always_comb begin
        bus.prod_ready = (r_state != StHold);
        bus.out_valid  = (r_state == StHold);
        busy           = (r_state != StIdle);
        bus.acc_out    = r_acc_out;
        bus.out_ovf    = r_out_ovf;
    end

    // Partial sum, word count and result registers; results latch only on entry to Hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc     <= '0;
            r_cnt     <= '0;
            r_ovf     <= 1'b0;
            r_acc_out <= '0;
            r_out_ovf <= 1'b0;
        end else if (r_state == StHold) begin
            if (bus.out_ready) begin
                r_acc <= '0;
                r_cnt <= '0;
            end
        end else if (w_xfer) begin
            r_acc <= w_acc_nxt;
            r_ovf <= w_ovf_nxt;
            r_cnt <= (r_state == StIdle) ? CntW'(1) : r_cnt + CntW'(1);
            if (w_last) begin
                r_acc_out <= w_acc_nxt;
                r_out_ovf <= w_ovf_nxt;
            end
        end
    end

endmodule

// File: tb/tb_ssm_acc.sv
// Bench for ssm_acc: three instances (LEN=4 / LEN=2 with ACC_W=32 / LEN=1),
// a frame-level reference model checked every cycle, directed scenarios with
// literal expectations, then randomized traffic. Honours SSM_ACC_SAT_EN.
module tb_ssm_acc;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    // Stimulus per instance (0: LEN=4, 1: LEN=2/ACC_W=32, 2: LEN=1)
    logic        tb_pv [3];
    logic [31:0] tb_pd [3];
    logic        tb_or [3];

    // Observed outputs, widened for a uniform compare
    logic [63:0] d_acc  [3];
    logic        d_ovf  [3];
    logic        d_ov   [3];
    logic        d_pr   [3];
    logic        d_busy [3];
    logic        busy_a, busy_b, busy_c;

    // Frame-level reference model
    int unsigned     m_len  [3] = '{4, 2, 1};
    int unsigned     m_w    [3] = '{34, 32, 32};
    bit              m_hold [3] = '{default: 1'b0};
    int unsigned     m_cnt  [3] = '{default: 0};
    longint unsigned m_sum  [3] = '{default: 0};
    longint unsigned m_out  [3] = '{default: 0};
    bit              m_ovf  [3] = '{default: 1'b0};

    ssm_acc_if #(.N(16), .ACC_W(34)) if_a ();
    ssm_acc_if #(.N(16), .ACC_W(32)) if_b ();
    ssm_acc_if #(.N(16), .ACC_W(32)) if_c ();

    ssm_acc #(.N(16), .LEN(4)) u_dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_a),
        .busy  (busy_a)
    );

    ssm_acc #(.N(16), .LEN(2), .ACC_W(32)) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_b),
        .busy  (busy_b)
    );

    ssm_acc #(.N(16), .LEN(1)) u_dut_c (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_c),
        .busy  (busy_c)
    );

    always #5 clk = ~clk;

    always_comb begin
        if_a.prod_valid = tb_pv[0];
        if_a.prod       = tb_pd[0];
        if_a.out_ready  = tb_or[0];
        if_b.prod_valid = tb_pv[1];
        if_b.prod       = tb_pd[1];
        if_b.out_ready  = tb_or[1];
        if_c.prod_valid = tb_pv[2];
        if_c.prod       = tb_pd[2];
        if_c.out_ready  = tb_or[2];
    end

    always_comb begin
        d_acc[0] = 64'(if_a.acc_out);
        d_acc[1] = 64'(if_b.acc_out);
        d_acc[2] = 64'(if_c.acc_out);
        d_ovf[0] = if_a.out_ovf;
        d_ovf[1] = if_b.out_ovf;
        d_ovf[2] = if_c.out_ovf;
        d_ov[0]  = if_a.out_valid;
        d_ov[1]  = if_b.out_valid;
        d_ov[2]  = if_c.out_valid;
        d_pr[0]  = if_a.prod_ready;
        d_pr[1]  = if_b.prod_ready;
        d_pr[2]  = if_c.prod_ready;
        d_busy[0] = busy_a;
        d_busy[1] = busy_b;
        d_busy[2] = busy_c;
    end

    task automatic chk(input string nm, input int id, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d] @%0t: got 'h%0h, want 'h%0h", nm, id, $time, act, exp);
        end
    endtask

    // Model rule: a frame is LEN accepted words; result is their true sum, with
    // overflow when that sum reaches 2^ACC_W (wrapped or clamped accordingly).
    task automatic model_step();
        longint unsigned mask;
        bit big;
        for (int i = 0; i < 3; i++) begin
            if (!rst_n) begin
                m_hold[i] = 1'b0;
                m_cnt[i]  = 0;
                m_sum[i]  = 0;
                m_out[i]  = 0;
                m_ovf[i]  = 1'b0;
            end else if (m_hold[i]) begin
                if (tb_or[i]) m_hold[i] = 1'b0;
            end else if (tb_pv[i]) begin
                m_sum[i] = ((m_cnt[i] == 0) ? 64'd0 : m_sum[i]) + 64'(tb_pd[i]);
                m_cnt[i]++;
                if (m_cnt[i] == m_len[i]) begin
                    mask = (64'd1 << m_w[i]) - 64'd1;
                    big  = (m_sum[i] > mask);
`ifdef SSM_ACC_SAT_EN
                    m_out[i] = big ? mask : m_sum[i];
`else
                    m_out[i] = m_sum[i] & mask;
`endif
                    m_ovf[i]  = big;
                    m_hold[i] = 1'b1;
                    m_cnt[i]  = 0;
                end
            end
        end
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        model_step();
    end

    // Every-cycle compare against the model, away from the active edge
    initial forever begin
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk("prod_ready", i, 64'(d_pr[i]), 64'(!m_hold[i]));
            chk("out_valid", i, 64'(d_ov[i]), 64'(m_hold[i]));
            chk("busy", i, 64'(d_busy[i]), 64'(m_hold[i] || m_cnt[i] != 0));
            chk("acc_out", i, d_acc[i], m_out[i]);
            chk("out_ovf", i, 64'(d_ovf[i]), 64'(m_ovf[i]));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Present one word and wait (bounded) until it is taken
    task automatic send(input int id, input logic [31:0] p);
        bit done;
        done      = 1'b0;
        tb_pv[id] = 1'b1;
        tb_pd[id] = p;
        for (int k = 0; k < 20 && !done; k++) begin
            done = d_pr[id];
            cyc();
        end
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout[%0d]: word 'h%0h not accepted in 20 cycles", id, p);
        end
    endtask

    logic [31:0] vals [4] = '{32'd100, 32'd200, 32'd300, 32'd400};
    int          n_valid;

    initial begin
        for (int i = 0; i < 3; i++) begin
            tb_pv[i] = 1'b0;
            tb_pd[i] = '0;
            tb_or[i] = 1'b1;
        end
        repeat (3) cyc();
        chk("rst_acc", 0, d_acc[0], 64'd0);
        chk("rst_valid", 0, 64'(d_ov[0]), 64'd0);
        rst_n = 1'b1;
        cyc();
        chk("rel_ready", 0, 64'(d_pr[0]), 64'd1);

        // Back-to-back frame
        for (int j = 0; j < 4; j++) send(0, vals[j]);
        tb_pv[0] = 1'b0;
        chk("t1_valid", 0, 64'(d_ov[0]), 64'd1);
        chk("t1_acc", 0, d_acc[0], 64'd1000);
        chk("t1_ovf", 0, 64'(d_ovf[0]), 64'd0);
        cyc();
        chk("t1_valid_lo", 0, 64'(d_ov[0]), 64'd0);
        chk("t1_ready", 0, 64'(d_pr[0]), 64'd1);

        // Valid toggled every other cycle; result then held under back-pressure
        tb_or[0] = 1'b0;
        for (int j = 0; j < 4; j++) begin
            send(0, vals[j]);
            tb_pv[0] = 1'b0;
            if (j < 3) begin
                chk("t2_ready", 0, 64'(d_pr[0]), 64'd1);
                cyc();
                chk("t2_ready_gap", 0, 64'(d_pr[0]), 64'd1);
            end
        end
        chk("t2_valid", 0, 64'(d_ov[0]), 64'd1);
        chk("t2_acc", 0, d_acc[0], 64'd1000);

        tb_pv[0] = 1'b1;
        tb_pd[0] = 32'd7;
        for (int j = 0; j < 5; j++) begin
            chk("t3_ready", 0, 64'(d_pr[0]), 64'd0);
            chk("t3_acc", 0, d_acc[0], 64'd1000);
            cyc();
        end
        tb_or[0] = 1'b1;
        for (int j = 0; j < 4; j++) send(0, 32'd7);
        tb_pv[0] = 1'b0;
        chk("t3_acc28", 0, d_acc[0], 64'd28);

        // Overflow at ACC_W=32, then a clean frame clears the flag
        send(1, 32'hFFFF_FFFF);
        send(1, 32'hFFFF_FFFF);
        tb_pv[1] = 1'b0;
`ifdef SSM_ACC_SAT_EN
        chk("t4_acc", 1, d_acc[1], 64'hFFFF_FFFF);
`else
        chk("t4_acc", 1, d_acc[1], 64'hFFFF_FFFE);
`endif
        chk("t4_ovf", 1, 64'(d_ovf[1]), 64'd1);
        send(1, 32'd1);
        send(1, 32'd1);
        tb_pv[1] = 1'b0;
        chk("t4b_acc", 1, d_acc[1], 64'd2);
        chk("t4b_ovf", 1, 64'(d_ovf[1]), 64'd0);

        // Asynchronous reset mid-frame discards the partial sum
        cyc();
        send(0, 32'd1);
        send(0, 32'd1);
        tb_pv[0] = 1'b0;
        chk("t5_busy_pre", 0, 64'(d_busy[0]), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_acc", 0, d_acc[0], 64'd0);
        chk("t5_valid", 0, 64'(d_ov[0]), 64'd0);
        chk("t5_ovf", 0, 64'(d_ovf[0]), 64'd0);
        chk("t5_busy", 0, 64'(d_busy[0]), 64'd0);
        #4 rst_n = 1'b1;
        cyc();
        for (int j = 0; j < 4; j++) send(0, 32'd1);
        tb_pv[0] = 1'b0;
        chk("t5_acc4", 0, d_acc[0], 64'd4);

        // LEN=1: one result every two cycles at full rate
        send(2, 32'h1234);
        chk("t6_valid", 2, 64'(d_ov[2]), 64'd1);
        chk("t6_acc", 2, d_acc[2], 64'h1234);
        tb_pd[2] = 32'h55;
        n_valid  = 0;
        for (int j = 0; j < 10; j++) begin
            if (d_ov[2]) n_valid++;
            cyc();
        end
        tb_pv[2] = 1'b0;
        chk("t6_rate", 2, 64'(n_valid), 64'd5);
        cyc();

        // Randomized traffic; a word stalled by Hold is kept stable
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < 3; i++) begin
                if (!(tb_pv[i] && m_hold[i])) begin
                    tb_pv[i] = ($urandom_range(0, 3) != 0);
                    tb_pd[i] = ($urandom_range(0, 1) == 1) ? $urandom : $urandom_range(0, 1000);
                end
                tb_or[i] = ($urandom_range(0, 3) != 0);
            end
            cyc();
        end
        for (int i = 0; i < 3; i++) tb_pv[i] = 1'b0;
        repeat (3) cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ssm_acc.md
Name: ssm_acc

Overview:
- Downstream consumer of the static-segment approximate multiplier.
- Takes its 2N-bit product stream under a valid/ready handshake and accumulates LEN products into one dot-product result.
- Presents the result on a second valid/ready interface with an overflow flag.
- Turns the combinational multiplier into a streaming MAC datapath.

Parameters:
- N, 16, operand width of the upstream multiplier; product width is 2N.
- LEN, 16, products per frame (>=1).
- ACC_W, 2*N+$clog2(LEN), accumulator/result width (>=2N).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- prod_valid  input  1  product word valid.
- prod_ready  output  1  block can accept a product this cycle.
- prod  input  2N  unsigned product from the multiplier.
- out_valid  output  1  frame result valid.
- out_ready  input  1  downstream accepts the result.
- acc_out  output  ACC_W  accumulated frame sum.
- out_ovf  output  1  frame overflowed ACC_W.
- busy  output  1  frame in progress (state != IDLE).

Behaviour:
- One clock (clk). Reset is asynchronous and active-low (rst_n).
- States:
  - IDLE: no partial sum.
  - ACC: 1..LEN-1 products summed.
  - HOLD: result presented.
- Reset (async, rst_n low) forces:
  - state=IDLE; acc=0; cnt=0; acc_out=0; out_valid=0; out_ovf=0.
  - prod_ready=1 on the first cycle after release.
  - Reset mid-frame discards the partial sum; no output is produced for that frame.
- prod_ready = (state != HOLD); purely decoded from state, with no combinational path from out_ready.
- Transfer = prod_valid & prod_ready, sampled on clk rising edge. prod must be held stable while prod_valid=1 and prod_ready=0.
- IDLE + transfer: acc <= zero-extended prod; cnt <= 1; ovf <= 0; next = ACC, or HOLD if LEN==1.
- ACC + transfer: acc <= acc + prod (ACC_W+1-bit sum); cnt <= cnt+1.
  - If cnt == LEN-1 before the increment: next = HOLD.
- No transfer: acc, cnt and state hold. Gaps of any length are allowed.
- HOLD:
  - out_valid=1; acc_out and out_ovf stable.
  - When out_ready=1: next = IDLE; out_valid=0; acc and cnt cleared.
  - No product is accepted in the HOLD->IDLE release cycle; the next frame starts at the earliest one cycle later.
- Latency: out_valid rises the cycle after the LEN-th transfer.
- Throughput: LEN+1 cycles per frame at full rate with out_ready tied high.
- Overflow: carry out of ACC_W sets a sticky ovf for the frame, cleared at the next frame's first transfer.
  - Without the macro, acc wraps modulo 2^ACC_W.
- acc_out and out_ovf are registered and change only on entry to HOLD or on reset.
- cnt width is $clog2(LEN+1).
- Elaboration error if LEN<1 or ACC_W<2N.

Optional Feature:
- Macro SSM_ACC_SAT_EN.
- Defined: on carry out, acc clamps to all-ones ({ACC_W{1'b1}}) and stays clamped for the rest of the frame; ovf=1.
- Undefined: wrap-around arithmetic; ovf still reported.
- Interface is identical in both builds.

Decomposition:
- Package ssm_pkg holds:
  - state typedef (IDLE/ACC/HOLD, 2-bit encoding);
  - default N/LEN constants;
  - a clog2-based width helper for ACC_W and cnt.
- One natural sub-module, ssm_sat_add: ACC_W accumulator + 2N addend.
  - Outputs are the sum and the carry.
  - Saturation sits under SSM_ACC_SAT_EN.
  - Purely combinational; instanced once.
- FSM, counter and output registers stay in ssm_acc.

Test Plan:
- N=16, LEN=4, out_ready=1; products 100,200,300,400 back-to-back -> one cycle after the 4th transfer: out_valid=1, acc_out=1000, out_ovf=0; next cycle out_valid=0, prod_ready=1.
- Same products, prod_valid toggled every other cycle -> acc_out=1000; prod_ready never drops during ACC; no duplicated or lost word.
- Back-pressure: out_ready=0 for 5 cycles after result, prod_valid=1 with prod=7 -> prod_ready=0 and acc_out=1000 stable throughout; after out_ready=1 the next frame 7,7,7,7 -> 28.
- ACC_W=32, LEN=2, products 0xFFFFFFFF twice -> without macro acc_out=0xFFFFFFFE, out_ovf=1; with SSM_ACC_SAT_EN acc_out=0xFFFFFFFF, out_ovf=1; following frame 1,1 -> 2, ovf=0.
- LEN=4: after 2 transfers pulse rst_n low mid-cycle -> all outputs 0 asynchronously, busy=0; frame 1,1,1,1 after release -> acc_out=4.
- LEN=1: product 0x1234 -> HOLD next cycle, acc_out=0x1234; consecutive frames with out_ready=1 yield one result per 2 cycles.
